// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS MEM-stage load/store unit: access sizes, LSU FSM states
// and the width helper for the ack-timeout counter.
package mips_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } lsu_state_t;

   // Counter must be able to hold max_count itself; a zero budget still needs one bit.
   function automatic int cnt_width(input int max_count);
      return (max_count < 2) ? 1 : $clog2(max_count + 1);
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store byte enables / lane-replicated data, and
// load lane extraction with sign or zero extension. BIG_ENDIAN selects the MIPS lane order.
module lsu_lane_align
   import mips_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic [1:0]  i_st_size,
   input  logic [1:0]  i_st_lane,
   input  logic [31:0] i_st_data,
   output logic [3:0]  o_st_be,
   output logic [31:0] o_st_data,
   input  logic [1:0]  i_ld_size,
   input  logic [1:0]  i_ld_lane,
   input  logic        i_ld_unsigned,
   input  logic [31:0] i_ld_word,
   output logic [31:0] o_ld_data
);

   logic [4:0]  w_shift;
   logic [31:0] w_shifted;

   always_comb begin
      o_st_be   = 4'b1111;
      o_st_data = i_st_data;
      case (i_st_size)
         SZ_BYTE: begin
            o_st_be   = BIG_ENDIAN ? (4'b1000 >> i_st_lane) : (4'b0001 << i_st_lane);
            o_st_data = {4{i_st_data[7:0]}};
         end
         SZ_HALF: begin
            if (BIG_ENDIAN) o_st_be = i_st_lane[1] ? 4'b0011 : 4'b1100;
            else            o_st_be = i_st_lane[1] ? 4'b1100 : 4'b0011;
            o_st_data = {2{i_st_data[15:0]}};
         end
         default: ;
      endcase
   end

   // Bring the addressed lane down to bit 0, then extend.
   always_comb begin
      w_shift = 5'd0;
      case (i_ld_size)
         SZ_BYTE: w_shift = BIG_ENDIAN ? {~i_ld_lane, 3'b000} : {i_ld_lane, 3'b000};
         SZ_HALF: w_shift = BIG_ENDIAN ? {~i_ld_lane[1], 4'b0000} : {i_ld_lane[1], 4'b0000};
         default: w_shift = 5'd0;
      endcase
   end

   assign w_shifted = i_ld_word >> w_shift;

   always_comb begin
      o_ld_data = w_shifted;
      case (i_ld_size)
         SZ_BYTE: o_ld_data = i_ld_unsigned ? {24'd0, w_shifted[7:0]}
                                            : {{24{w_shifted[7]}}, w_shifted[7:0]};
         SZ_HALF: o_ld_data = i_ld_unsigned ? {16'd0, w_shifted[15:0]}
                                            : {{16{w_shifted[15]}}, w_shifted[15:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: one access per stall window over a req/ack word bus.
// Optional MISALIGN_TRAP_EN traps misaligned half/word accesses instead of forcing alignment.
module load_store_unit
   import mips_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter bit BIG_ENDIAN     = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        op_valid,
   input  logic        op_write,
   input  logic [1:0]  op_size,
   input  logic        op_unsigned,
   input  logic [31:0] op_addr,
   input  logic [31:0] op_wdata,
   input  logic [4:0]  op_rd,
   output logic        stall,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        bus_err,
   output logic        exc_misalign,
   output logic [31:0] exc_addr,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output lsu_state_t  dbg_state
);

   localparam int            CW     = cnt_width(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);

   lsu_state_t  r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic        r_we, r_unsigned, r_ld_ok, r_err;
   logic [31:0] r_addr, r_wdata, r_wb_data;
   logic [3:0]  r_be;
   logic [4:0]  r_rd;
   logic [1:0]  r_size, r_lane;
   logic        w_accept, w_timeout, w_misalign;
   logic [3:0]  w_st_be;
   logic [31:0] w_st_data, w_ld_data;
`ifdef MISALIGN_TRAP_EN
   logic        r_mis;
   logic [31:0] r_exc_addr;
`endif

   lsu_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
      .i_st_size     (op_size),
      .i_st_lane     (op_addr[1:0]),
      .i_st_data     (op_wdata),
      .o_st_be       (w_st_be),
      .o_st_data     (w_st_data),
      .i_ld_size     (r_size),
      .i_ld_lane     (r_lane),
      .i_ld_unsigned (r_unsigned),
      .i_ld_word     (mem_rdata),
      .o_ld_data     (w_ld_data)
   );

   assign w_accept  = (r_state == ST_IDLE) && op_valid;
   // An ack on the final allowed cycle still wins over the timeout.
   assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_VAL) && !mem_ack;

`ifdef MISALIGN_TRAP_EN
   assign w_misalign = ((op_size == SZ_HALF) && op_addr[0]) ||
                       (op_size[1] && (op_addr[1:0] != 2'b00));
`else
   assign w_misalign = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (op_valid) w_next = w_misalign ? ST_DONE : ST_BUSY;
         ST_BUSY: if (mem_ack || w_timeout) w_next = ST_DONE;
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      stall        = 1'b0;
      mem_req      = 1'b0;
      wb_valid     = 1'b0;
      bus_err      = 1'b0;
      exc_misalign = 1'b0;
      case (r_state)
         ST_IDLE: stall = op_valid;
         ST_BUSY: begin
            stall   = 1'b1;
            mem_req = 1'b1;
         end
         ST_DONE: begin
            wb_valid = r_ld_ok;
            bus_err  = r_err;
`ifdef MISALIGN_TRAP_EN
            exc_misalign = r_mis;
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cnt      <= '0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_be       <= '0;
         r_wdata    <= '0;
         r_rd       <= '0;
         r_size     <= '0;
         r_lane     <= '0;
         r_unsigned <= 1'b0;
         r_wb_data  <= '0;
         r_ld_ok    <= 1'b0;
         r_err      <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         r_mis      <= 1'b0;
         r_exc_addr <= '0;
`endif
      end else begin
         if (w_accept) begin
            r_we       <= op_write;
            r_addr     <= {op_addr[31:2], 2'b00};
            r_be       <= w_st_be;
            r_wdata    <= w_st_data;
            r_rd       <= op_rd;
            r_size     <= op_size;
            r_lane     <= op_addr[1:0];
            r_unsigned <= op_unsigned;
            r_ld_ok    <= 1'b0;
            r_err      <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            r_mis      <= w_misalign;
            r_exc_addr <= op_addr;
`endif
         end
         if (r_state == ST_BUSY) begin
            r_cnt <= r_cnt + 1'b1;
            if (mem_ack) begin
               r_wb_data <= w_ld_data;
               r_ld_ok   <= !r_we;
            end else if (w_timeout) begin
               r_err <= 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign mem_we    = r_we;
   assign mem_addr  = r_addr;
   assign mem_be    = r_be;
   assign mem_wdata = r_wdata;
   assign wb_rd     = r_rd;
   assign wb_data   = r_wb_data;
   assign dbg_state = r_state;
`ifdef MISALIGN_TRAP_EN
   assign exc_addr  = r_exc_addr;
`else
   assign exc_addr  = 32'd0;
`endif

endmodule
